uart_cmd_parser: RTL and testbench

//  Frames the byte stream from the UART receiver into fixed-length laser-control commands.

---
 rtl/uart_cmd_pkg.sv | 28 ++
 rtl/cmd_timeout.sv | 42 ++++
 rtl/uart_cmd_parser.sv | 173 +++++++++++++++++
 tb/tb_uart_cmd_parser.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_pkg.sv
// ----------------------------------------------------------------------------
// uart_cmd_pkg
//   Shared definitions for the UART laser-command parser: the default frame
//   start marker, the parser state encoding and the command codes understood
//   by the galvo/laser control logic downstream.
// ----------------------------------------------------------------------------
package uart_cmd_pkg;

    // Default frame start marker.
    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    // Parser states. ST_CHK is only reachable when the checksum byte is
    // enabled (UART_CMD_PARSER_CHECKSUM_EN).
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CMD  = 3'd1,
        ST_DHI  = 3'd2,
        ST_DLO  = 3'd3,
        ST_CHK  = 3'd4
    } state_t;

    // Command codes carried in the CMD byte.
    localparam logic [7:0] CMD_NOP   = 8'h00;
    localparam logic [7:0] CMD_LASER = 8'h01;
    localparam logic [7:0] CMD_X     = 8'h10;
    localparam logic [7:0] CMD_Y     = 8'h11;

endpackage : uart_cmd_pkg

// File: rtl/cmd_timeout.sv
// ----------------------------------------------------------------------------
// cmd_timeout
//   Inter-byte timeout counter for the command parser. Counts enabled cycles
//   since the last clear and saturates at TIMEOUT_CYCLES-1 (never wraps).
//
// Ports
//   clk      in   1  system clock
//   rst_n    in   1  asynchronous active-low reset
//   clear    in   1  synchronous clear (takes priority over enable)
//   enable   in   1  count this cycle
//   expired  out  1  counter has reached TIMEOUT_CYCLES-1
// ----------------------------------------------------------------------------
module cmd_timeout #(
    parameter int TIMEOUT_CYCLES = 120000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count;

    assign expired = (count == CNT_MAX);

    // NOTE: sequential state is written with non-blocking assignments only,
    // so every register samples the pre-edge value of every other register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 1'b1;
        end
    end

endmodule : cmd_timeout

// File: rtl/uart_cmd_parser.sv
// ----------------------------------------------------------------------------
// uart_cmd_parser
//   Frames the byte stream from the UART receiver into fixed-length
//   laser-control commands and emits one validated {cmd, data} word per frame.
//   Malformed frames (inter-byte timeout, and bad checksum when enabled) are
//   discarded with a one-cycle frame_err pulse.
//
//   Frame: SYNC, CMD, DATA_HI, DATA_LO [, CHK]
//   Build option: define UART_CMD_PARSER_CHECKSUM_EN to add the trailing CHK
//   byte (CMD ^ DATA_HI ^ DATA_LO). Without it the frame is 4 bytes long.
//
// Ports
//   clk        in   1   system clock
//   rst_n      in   1   asynchronous active-low reset
//   rx_byte    in   8   byte from UART receiver, stable while rx_latch high
//   rx_latch   in   1   receiver byte-ready level (may stay high many cycles)
//   cmd        out  8   command code of last good frame
//   data       out  16  payload of last good frame, {DATA_HI, DATA_LO}
//   cmd_valid  out  1   one-cycle pulse: cmd/data updated this cycle
//   frame_err  out  1   one-cycle pulse: frame discarded
//   busy       out  1   high while a frame is in progress
// ----------------------------------------------------------------------------
module uart_cmd_parser
    import uart_cmd_pkg::*;
#(
    parameter int         TIMEOUT_CYCLES = 120000,
    parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_byte,
    input  logic        rx_latch,
    output logic [7:0]  cmd,
    output logic [15:0] data,
    output logic        cmd_valid,
    output logic        frame_err,
    output logic        busy
);

    state_t     state;
    logic       rx_latch_q;
    logic       byte_stb;
    logic       to_expired;
    logic       timed_out;
    logic [7:0] cmd_q;
    logic [7:0] dhi_q;
`ifdef UART_CMD_PARSER_CHECKSUM_EN
    logic [7:0] dlo_q;
    logic [7:0] csum;
`endif

    // ------------------------------------------------------------------
    // Byte strobe: rising edge of the receiver's latch level.
    // ------------------------------------------------------------------
    assign byte_stb = rx_latch & ~rx_latch_q;

    // History resets to 1 so a latch already high when reset is released
    // is treated as stale and not consumed as a new byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_latch_q <= 1'b1;
        end else begin
            rx_latch_q <= rx_latch;
        end
    end

    // ------------------------------------------------------------------
    // Inter-byte timeout: idle in IDLE, restarted by every consumed byte.
    // ------------------------------------------------------------------
    cmd_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (byte_stb | (state == ST_IDLE)),
        .enable  (state != ST_IDLE),
        .expired (to_expired)
    );

    assign timed_out = to_expired & (state != ST_IDLE);
    assign busy      = (state != ST_IDLE);

    // ------------------------------------------------------------------
    // Frame FSM with registered outputs. A consumed byte always takes
    // priority over a timeout in the same cycle, which also guarantees that
    // cmd_valid and frame_err are never raised together.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cmd       <= '0;
            data      <= '0;
            cmd_valid <= 1'b0;
            frame_err <= 1'b0;
            cmd_q     <= '0;
            dhi_q     <= '0;
`ifdef UART_CMD_PARSER_CHECKSUM_EN
            dlo_q     <= '0;
`endif
        end else begin
            cmd_valid <= 1'b0;
            frame_err <= 1'b0;

            if (byte_stb) begin
                case (state)
                    // Anything but the marker is dropped silently.
                    ST_IDLE: begin
                        if (rx_byte == SYNC_BYTE) begin
                            state <= ST_CMD;
                        end
                    end
                    // Payload bytes are taken verbatim, even if equal to the
                    // marker: there is no resynchronisation mid-frame.
                    ST_CMD: begin
                        cmd_q <= rx_byte;
                        state <= ST_DHI;
                    end
                    ST_DHI: begin
                        dhi_q <= rx_byte;
                        state <= ST_DLO;
                    end
                    ST_DLO: begin
`ifdef UART_CMD_PARSER_CHECKSUM_EN
                        dlo_q <= rx_byte;
                        state <= ST_CHK;
`else
                        cmd       <= cmd_q;
                        data      <= {dhi_q, rx_byte};
                        cmd_valid <= 1'b1;
                        state     <= ST_IDLE;
`endif
                    end
`ifdef UART_CMD_PARSER_CHECKSUM_EN
                    ST_CHK: begin
                        if (rx_byte == csum) begin
                            cmd       <= cmd_q;
                            data      <= {dhi_q, dlo_q};
                            cmd_valid <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                        state <= ST_IDLE;
                    end
`endif
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end else if (timed_out) begin
                // Partial frame is abandoned; the next SYNC starts afresh.
                frame_err <= 1'b1;
                state     <= ST_IDLE;
            end
        end
    end

`ifdef UART_CMD_PARSER_CHECKSUM_EN
    // ------------------------------------------------------------------
    // Running XOR of CMD, DATA_HI and DATA_LO; cleared while idle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum <= '0;
        end else if (state == ST_IDLE) begin
            csum <= '0;
        end else if (byte_stb &&
                     (state == ST_CMD || state == ST_DHI || state == ST_DLO)) begin
            csum <= csum ^ rx_byte;
        end
    end
`endif

endmodule : uart_cmd_parser

// File: tb/tb_uart_cmd_parser.sv
// ----------------------------------------------------------------------------
// tb_uart_cmd_parser
//   Directed, self-checking bench for uart_cmd_parser. Uses a short timeout so
//   the timeout scenario stays small. Works with or without
//   UART_CMD_PARSER_CHECKSUM_EN defined.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_cmd_parser;
    import uart_cmd_pkg::*;

    localparam int TO = 1000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_byte;
    logic        rx_latch;
    logic [7:0]  cmd;
    logic [15:0] data;
    logic        cmd_valid;
    logic        frame_err;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Pulse counters, written only by the monitor below.
    int cv_count   = 0;
    int fe_count   = 0;
    int both_count = 0;

    uart_cmd_parser #(
        .TIMEOUT_CYCLES (TO),
        .SYNC_BYTE      (8'hA5)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_byte   (rx_byte),
        .rx_latch  (rx_latch),
        .cmd       (cmd),
        .data      (data),
        .cmd_valid (cmd_valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cmd_valid) cv_count++;
        if (frame_err) fe_count++;
        if (cmd_valid && frame_err) both_count++;
    end

    // One byte: latch rises at a negedge, is held `hold` cycles, then drops
    // for one cycle. Outputs are sampled 1 ns after the first edge seeing it.
    task automatic send_byte(input logic [7:0] b, input int hold,
                             output logic cv_after, output logic fe_after);
        @(negedge clk);
        rx_byte  = b;
        rx_latch = 1'b1;
        @(posedge clk);
        #1;
        cv_after = cmd_valid;
        fe_after = frame_err;
        repeat (hold) @(negedge clk);
        rx_latch = 1'b0;
        @(negedge clk);
    endtask

    // Full good frame; returns the strobes seen right after the final byte.
    task automatic send_frame(input logic [7:0] c, input logic [7:0] hi,
                              input logic [7:0] lo, input int hold,
                              output logic cv_last, output logic fe_last);
        logic cv, fe;
        send_byte(8'hA5, hold, cv, fe);
        send_byte(c, hold, cv, fe);
        send_byte(hi, hold, cv, fe);
        send_byte(lo, hold, cv, fe);
`ifdef UART_CMD_PARSER_CHECKSUM_EN
        send_byte(c ^ hi ^ lo, hold, cv, fe);
`endif
        cv_last = cv;
        fe_last = fe;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        rx_byte  = 8'hA5;
        rx_latch = 1'b1;            // held high through reset
        repeat (3) @(negedge clk);
        n_checks++; if (cmd !== 8'h00) begin n_fail++; $display("FAIL reset_cmd got=%h exp=00", cmd); end
        n_checks++; if (data !== 16'h0000) begin n_fail++; $display("FAIL reset_data got=%h exp=0000", data); end
        n_checks++; if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_cmd_valid got=%b exp=0", cmd_valid); end
        n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err got=%b exp=0", frame_err); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        // Stale latch level must not be consumed as a SYNC byte.
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL stale_latch_busy got=%b exp=0", busy); end
        rx_latch = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_good_frame();
        logic cv, fe;
        int cv0, fe0;
        cv0 = cv_count; fe0 = fe_count;
        send_frame(CMD_X, 8'h12, 8'h34, 1, cv, fe);
        n_checks++; if (cv !== 1'b1) begin n_fail++; $display("FAIL good_latency cmd_valid got=%b exp=1", cv); end
        n_checks++; if (cmd !== 8'h10) begin n_fail++; $display("FAIL good_cmd got=%h exp=10", cmd); end
        n_checks++; if (data !== 16'h1234) begin n_fail++; $display("FAIL good_data got=%h exp=1234", data); end
        n_checks++; if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL good_pulse_width cmd_valid got=%b exp=0", cmd_valid); end
        n_checks++; if (cv_count - cv0 !== 1) begin n_fail++; $display("FAIL good_cv_count got=%0d exp=1", cv_count - cv0); end
        n_checks++; if (fe_count - fe0 !== 0) begin n_fail++; $display("FAIL good_fe_count got=%0d exp=0", fe_count - fe0); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL good_busy got=%b exp=0", busy); end
    endtask

    task automatic test_junk();
        logic cv, fe;
        int cv0, fe0;
        cv0 = cv_count; fe0 = fe_count;
        send_byte(8'h00, 1, cv, fe);
        send_byte(8'hFF, 1, cv, fe);
        send_byte(8'h5A, 1, cv, fe);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL junk_busy got=%b exp=0", busy); end
        send_frame(CMD_LASER, 8'h00, 8'h01, 1, cv, fe);
        n_checks++; if (fe_count - fe0 !== 0) begin n_fail++; $display("FAIL junk_fe_count got=%0d exp=0", fe_count - fe0); end
        n_checks++; if (cv_count - cv0 !== 1) begin n_fail++; $display("FAIL junk_cv_count got=%0d exp=1", cv_count - cv0); end
        n_checks++; if (cmd !== 8'h01) begin n_fail++; $display("FAIL junk_cmd got=%h exp=01", cmd); end
        n_checks++; if (data !== 16'h0001) begin n_fail++; $display("FAIL junk_data got=%h exp=0001", data); end
    endtask

`ifdef UART_CMD_PARSER_CHECKSUM_EN
    task automatic test_bad_checksum();
        logic cv, fe;
        int cv0, fe0;
        cv0 = cv_count; fe0 = fe_count;
        send_byte(8'hA5, 1, cv, fe);
        send_byte(8'h10, 1, cv, fe);
        send_byte(8'h12, 1, cv, fe);
        send_byte(8'h34, 1, cv, fe);
        send_byte(8'h47, 1, cv, fe);   // correct value would be 8'h36
        n_checks++; if (fe !== 1'b1) begin n_fail++; $display("FAIL csum_frame_err got=%b exp=1", fe); end
        n_checks++; if (fe_count - fe0 !== 1) begin n_fail++; $display("FAIL csum_fe_count got=%0d exp=1", fe_count - fe0); end
        n_checks++; if (cv_count - cv0 !== 0) begin n_fail++; $display("FAIL csum_cv_count got=%0d exp=0", cv_count - cv0); end
        n_checks++; if (cmd !== 8'h01) begin n_fail++; $display("FAIL csum_cmd_held got=%h exp=01", cmd); end
        n_checks++; if (data !== 16'h0001) begin n_fail++; $display("FAIL csum_data_held got=%h exp=0001", data); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL csum_busy got=%b exp=0", busy); end
    endtask
`endif

    task automatic test_timeout();
        logic cv, fe;
        int cv0, fe0;
        send_byte(8'hA5, 1, cv, fe);
        send_byte(8'h10, 1, cv, fe);
        cv0 = cv_count; fe0 = fe_count;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL timeout_busy_before got=%b exp=1", busy); end
        repeat (TO - 20) @(negedge clk);
        n_checks++; if (fe_count - fe0 !== 0) begin n_fail++; $display("FAIL timeout_early got=%0d exp=0", fe_count - fe0); end
        repeat (70) @(negedge clk);    // bounded wait past the timeout point
        n_checks++; if (fe_count - fe0 !== 1) begin n_fail++; $display("FAIL timeout_fe_count got=%0d exp=1", fe_count - fe0); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL timeout_busy_after got=%b exp=0", busy); end
        n_checks++; if (cv_count - cv0 !== 0) begin n_fail++; $display("FAIL timeout_cv_count got=%0d exp=0", cv_count - cv0); end
        send_frame(CMD_Y, 8'hAB, 8'hCD, 1, cv, fe);
        n_checks++; if (cv !== 1'b1) begin n_fail++; $display("FAIL timeout_recover_valid got=%b exp=1", cv); end
        n_checks++; if (cmd !== 8'h11) begin n_fail++; $display("FAIL timeout_recover_cmd got=%h exp=11", cmd); end
        n_checks++; if (data !== 16'hABCD) begin n_fail++; $display("FAIL timeout_recover_data got=%h exp=abcd", data); end
    endtask

    task automatic test_long_latch();
        logic cv, fe;
        int cv0, fe0;
        cv0 = cv_count; fe0 = fe_count;
        send_frame(CMD_LASER, 8'h00, 8'hFF, 500, cv, fe);
        n_checks++; if (cv_count - cv0 !== 1) begin n_fail++; $display("FAIL long_cv_count got=%0d exp=1", cv_count - cv0); end
        n_checks++; if (fe_count - fe0 !== 0) begin n_fail++; $display("FAIL long_fe_count got=%0d exp=0", fe_count - fe0); end
        n_checks++; if (cmd !== 8'h01) begin n_fail++; $display("FAIL long_cmd got=%h exp=01", cmd); end
        n_checks++; if (data !== 16'h00FF) begin n_fail++; $display("FAIL long_data got=%h exp=00ff", data); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL long_busy got=%b exp=0", busy); end
    endtask

    task automatic test_reset_mid_frame();
        logic cv, fe;
        int cv0;
        send_byte(8'hA5, 1, cv, fe);
        send_byte(8'h10, 1, cv, fe);
        send_byte(8'h12, 1, cv, fe);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midrst_busy_before got=%b exp=1", busy); end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (cmd !== 8'h00) begin n_fail++; $display("FAIL midrst_cmd got=%h exp=00", cmd); end
        n_checks++; if (data !== 16'h0000) begin n_fail++; $display("FAIL midrst_data got=%h exp=0000", data); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got=%b exp=0", busy); end
        n_checks++; if ({cmd_valid, frame_err} !== 2'b00) begin n_fail++; $display("FAIL midrst_pulses got=%b exp=00", {cmd_valid, frame_err}); end
        @(negedge clk);
        rst_n = 1'b1;
        cv0 = cv_count;
        send_byte(8'h34, 1, cv, fe);   // stray DLO: must be ignored in IDLE
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_stray_busy got=%b exp=0", busy); end
        n_checks++; if (cv_count - cv0 !== 0) begin n_fail++; $display("FAIL midrst_stray_cv got=%0d exp=0", cv_count - cv0); end
        send_frame(CMD_X, 8'h56, 8'h78, 1, cv, fe);
        n_checks++; if (cmd !== 8'h10) begin n_fail++; $display("FAIL midrst_next_cmd got=%h exp=10", cmd); end
        n_checks++; if (data !== 16'h5678) begin n_fail++; $display("FAIL midrst_next_data got=%h exp=5678", data); end
    endtask

    task automatic test_back_to_back();
        logic cv, fe;
        int cv0;
        cv0 = cv_count;
        send_frame(CMD_X, 8'hA5, 8'hA5, 1, cv, fe);   // marker value as payload
        n_checks++; if (data !== 16'hA5A5) begin n_fail++; $display("FAIL b2b_sync_payload got=%h exp=a5a5", data); end
        send_frame(CMD_NOP, 8'h02, 8'h00, 1, cv, fe);
        n_checks++; if (cv_count - cv0 !== 2) begin n_fail++; $display("FAIL b2b_cv_count got=%0d exp=2", cv_count - cv0); end
        n_checks++; if (cmd !== 8'h00) begin n_fail++; $display("FAIL b2b_cmd got=%h exp=00", cmd); end
        n_checks++; if (data !== 16'h0200) begin n_fail++; $display("FAIL b2b_data got=%h exp=0200", data); end
        n_checks++; if (both_count !== 0) begin n_fail++; $display("FAIL valid_err_overlap got=%0d exp=0", both_count); end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_junk();
`ifdef UART_CMD_PARSER_CHECKSUM_EN
        test_bad_checksum();
`endif
        test_timeout();
        test_long_latch();
        test_reset_mid_frame();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_uart_cmd_parser
